// File: rtl/loc_sweeper_pkg.sv
// Shared raster parameters and the location record passed between the
// counter, the delay line and the env cache.
package loc_sweeper_pkg;

    localparam int X_bits     = 10;
    localparam int Y_bits     = 9;
    localparam int PIXELS_X   = 639;
    localparam int PIXELS_Y   = 479;
    localparam int PIPE_DEPTH = 2;
    localparam bit DEBUG_MODE = 1'b0;

    typedef struct packed {
        logic [X_bits-1:0] x;
        logic [Y_bits-1:0] y;
    } loc_t;

    // Raster-order successor; wraps to (0,0) after (last_x,last_y).
    function automatic loc_t next_loc(loc_t cur, int unsigned last_x, int unsigned last_y);
        loc_t nxt;
        nxt = cur;
        if (cur.x == X_bits'(last_x)) begin
            nxt.x = '0;
            if (cur.y == Y_bits'(last_y)) nxt.y = '0;
            else                          nxt.y = cur.y + Y_bits'(1);
        end else begin
            nxt.x = cur.x + X_bits'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/loc_sweeper_delay_line.sv
// Enable-gated shift register of locations with a valid bit per stage;
// the oldest stage is presented at the output.
module loc_delay_line
    import loc_sweeper_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  loc_t in_loc,
    output loc_t out_loc,
    output logic out_valid
);

    loc_t             stage_q [DEPTH];
    loc_t             stage_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = '0;
            valid_d = '0;
        end else if (en) begin
            stage_d[0] = in_loc;
            valid_d[0] = 1'b1;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
        valid_q <= valid_d;
    end

    assign out_loc   = stage_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/loc_sweeper.sv
// Raster location generator: leading read location, write location delayed
// by PIPE_DEPTH advances, frame-done pulse and frame counter.
module loc_sweeper #(
    parameter int PIXELS_X   = loc_sweeper_pkg::PIXELS_X,
    parameter int PIXELS_Y   = loc_sweeper_pkg::PIXELS_Y,
    parameter int PIPE_DEPTH = loc_sweeper_pkg::PIPE_DEPTH,
    parameter int FC_bits    = 16
) (
    input  logic                              newLocClock,
    input  logic                              Reset,
    input  logic                              hold_locs,
    output logic [loc_sweeper_pkg::X_bits-1:0] readLoc_x,
    output logic [loc_sweeper_pkg::Y_bits-1:0] readLoc_y,
    output logic [loc_sweeper_pkg::X_bits-1:0] writeLoc_x,
    output logic [loc_sweeper_pkg::Y_bits-1:0] writeLoc_y,
    output logic                              write_valid,
    output logic                              frame_done,
    output logic [FC_bits-1:0]                frame_count
);
    import loc_sweeper_pkg::*;

    localparam int FILL_W = $clog2(PIPE_DEPTH + 1);

    if (PIXELS_X >= (1 << X_bits)) begin : g_bad_pixels_x
        $error("PIXELS_X does not fit in X_bits");
    end
    if (PIXELS_Y >= (1 << Y_bits)) begin : g_bad_pixels_y
        $error("PIXELS_Y does not fit in Y_bits");
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
        $error("PIPE_DEPTH must be 1..8");
    end

    logic               advance;
    loc_t               read_q, read_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               frame_done_q, frame_done_d;
    logic [FC_bits-1:0] frame_count_q, frame_count_d;
    loc_t               write_loc;
    logic               dl_valid;
    logic               write_valid_w;

    assign advance = !Reset && !hold_locs;

    loc_delay_line #(
        .DEPTH(PIPE_DEPTH)
    ) u_delay (
        .clk      (newLocClock),
        .rst      (Reset),
        .en       (advance),
        .in_loc   (read_q),
        .out_loc  (write_loc),
        .out_valid(dl_valid)
    );

    assign write_valid_w = dl_valid && (fill_q == FILL_W'(PIPE_DEPTH));

    always_comb begin
        read_d        = read_q;
        fill_d        = fill_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        if (Reset) begin
            read_d        = '0;
            fill_d        = '0;
            frame_count_d = '0;
        end else if (advance) begin
            read_d = next_loc(read_q, PIXELS_X, PIXELS_Y);
            if (fill_q != FILL_W'(PIPE_DEPTH)) fill_d = fill_q + FILL_W'(1);
            // Pulse marks the edge on which writeLoc leaves bottom-right.
            if (write_valid_w && write_loc.x == X_bits'(PIXELS_X)
                              && write_loc.y == Y_bits'(PIXELS_Y)) begin
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + FC_bits'(1);
            end
        end
    end

    always_ff @(posedge newLocClock) begin
        read_q        <= read_d;
        fill_q        <= fill_d;
        frame_done_q  <= frame_done_d;
        frame_count_q <= frame_count_d;
    end

    assign readLoc_x   = read_q.x;
    assign readLoc_y   = read_q.y;
    assign writeLoc_x  = write_loc.x;
    assign writeLoc_y  = write_loc.y;
    assign write_valid = write_valid_w;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_loc_sweeper.sv
// Self-checking bench for loc_sweeper on a 4x3 raster with a 2-deep pipe.
module tb_loc_sweeper;

    localparam int PX   = 3;
    localparam int PY   = 2;
    localparam int D    = 2;
    localparam int FCB  = 4;
    localparam int NPIX = (PX + 1) * (PY + 1);

    logic          clk = 1'b0;
    logic          reset_i;
    logic          hold_i;
    logic [9:0]    rx, wx;
    logic [8:0]    ry, wy;
    logic          wv, fd;
    logic [FCB-1:0] fc;

    int checks = 0;
    int errors = 0;

    // Model state: advances since reset and last-edge frame pulse.
    int n = 0;
    bit fd_m = 1'b0;

    loc_sweeper #(
        .PIXELS_X  (PX),
        .PIXELS_Y  (PY),
        .PIPE_DEPTH(D),
        .FC_bits   (FCB)
    ) dut (
        .newLocClock(clk),
        .Reset      (reset_i),
        .hold_locs  (hold_i),
        .readLoc_x  (rx),
        .readLoc_y  (ry),
        .writeLoc_x (wx),
        .writeLoc_y (wy),
        .write_valid(wv),
        .frame_done (fd),
        .frame_count(fc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int ridx;
        int widx;
        int fcm;
        bit wvm;
        ridx = n % NPIX;
        wvm  = (n >= D);
        widx = wvm ? (n - D) % NPIX : 0;
        fcm  = wvm ? ((n - D) / NPIX) % (1 << FCB) : 0;
        chk({tag, ".rx"}, int'(rx), ridx % (PX + 1));
        chk({tag, ".ry"}, int'(ry), ridx / (PX + 1));
        chk({tag, ".wx"}, int'(wx), widx % (PX + 1));
        chk({tag, ".wy"}, int'(wy), widx / (PX + 1));
        chk({tag, ".wv"}, int'(wv), int'(wvm));
        chk({tag, ".fd"}, int'(fd), int'(fd_m));
        chk({tag, ".fc"}, int'(fc), fcm);
    endtask

    task automatic step(input bit rst, input bit hold, input string tag);
        reset_i = rst;
        hold_i  = hold;
        @(posedge clk);
        #1;
        if (rst) begin
            n    = 0;
            fd_m = 1'b0;
        end else if (!hold) begin
            fd_m = (n >= D) && ((n - D) % NPIX == NPIX - 1);
            n++;
        end else begin
            fd_m = 1'b0;
        end
        check_model(tag);
    endtask

    function automatic int model_widx();
        return (n >= D) ? (n - D) % NPIX : -1;
    endfunction

    typedef struct {
        bit rst;
        bit hold;
        int rx, ry, wx, wy;
        bit wv, fd;
        int fc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset_i = 1'b1;
        hold_i  = 1'b0;

        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 2, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 3, 0, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 2, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 3, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 2, 1, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 2, 1, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 0, 3, 1, 1, 1, 1, 0, 0});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].hold, "tbl");
            chk("tbl.rx", int'(rx), tbl[i].rx);
            chk("tbl.ry", int'(ry), tbl[i].ry);
            chk("tbl.wx", int'(wx), tbl[i].wx);
            chk("tbl.wy", int'(wy), tbl[i].wy);
            chk("tbl.wv", int'(wv), int'(tbl[i].wv));
            chk("tbl.fd", int'(fd), int'(tbl[i].fd));
            chk("tbl.fc", int'(fc), tbl[i].fc);
        end

        // Free-run to bottom-right, take the interlock advance, then park.
        for (int k = 0; k < 100 && model_widx() != NPIX - 1; k++) step(1'b0, 1'b0, "run");
        chk("pre_park.wx", int'(wx), PX);
        chk("pre_park.wy", int'(wy), PY);
        step(1'b0, 1'b0, "last_adv");
        chk("park.fd", int'(fd), 1);
        chk("park.fc", int'(fc), 1);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, "held");
            chk("held.wx", int'(wx), 0);
            chk("held.wy", int'(wy), 0);
            chk("held.rx", int'(rx), D % (PX + 1));
            chk("held.ry", int'(ry), D / (PX + 1));
            chk("held.fd", int'(fd), 0);
        end

        for (int k = 0; k < 24; k++) step(1'b0, (k % 2) == 0, "toggle");

        // Reset with hold high while writeLoc sits at (2,1).
        for (int k = 0; k < 100 && model_widx() != 1 * (PX + 1) + 2; k++) step(1'b0, 1'b0, "seek");
        chk("pre_rst.wx", int'(wx), 2);
        chk("pre_rst.wy", int'(wy), 1);
        step(1'b1, 1'b1, "rst_hold");
        chk("rst.rx", int'(rx), 0);
        chk("rst.ry", int'(ry), 0);
        chk("rst.wx", int'(wx), 0);
        chk("rst.wy", int'(wy), 0);
        chk("rst.wv", int'(wv), 0);
        chk("rst.fc", int'(fc), 0);

        // 16+ frames: counter wraps 15->0 with the pulse still present.
        for (int k = 0; k < 17 * NPIX + D; k++) begin
            step(1'b0, 1'b0, "frames");
            if (fd_m && ((n - 1 - D) / NPIX + 1) % (1 << FCB) == 0) begin
                chk("wrap.fd", int'(fd), 1);
                chk("wrap.fc", int'(fc), 0);
            end
        end

        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loc_sweeper.md
Name: loc_sweeper

Overview:
- Raster location generator that drives the screen walk consumed by the simulation-state controller and the env cache.
- Produces a leading read location for env-cache fetch and a write location delayed by PIPE_DEPTH advances, which feeds writeLoc_x/writeLoc_y.
- Freezes while hold_locs is high, so exactly one full walk happens per game step.
- Also reports frame completion and counts frames.

Parameters:
- X_bits, 10, width of x coordinate.
- Y_bits, 9, width of y coordinate.
- PIXELS_X, 639, last x value (inclusive); x runs 0..PIXELS_X.
- PIXELS_Y, 479, last y value (inclusive); y runs 0..PIXELS_Y.
- PIPE_DEPTH, 2, advances between a location being read and being written; legal 1..8.
- FC_bits, 16, frame counter width.

Ports:
- newLocClock  in  1  sole clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- hold_locs  in  1  1 = freeze all state this edge.
- readLoc_x  out  X_bits  leading x for env-cache read.
- readLoc_y  out  Y_bits  leading y.
- writeLoc_x  out  X_bits  delayed x for write/controller.
- writeLoc_y  out  Y_bits  delayed y.
- write_valid  out  1  1 once the delay line holds real locations.
- frame_done  out  1  one-cycle pulse: writeLoc just left (PIXELS_X,PIXELS_Y).
- frame_count  out  FC_bits  completed write frames.

Behaviour:
- Reset (sampled at clock edge, overrides hold_locs):
  - All locations 0.
  - write_valid 0, frame_done 0, frame_count 0.
  - Delay line entries 0 and marked invalid.
- Advance: any edge with Reset=0 and hold_locs=0.
  - Read counter steps raster order: x+1; at x==PIXELS_X, x←0 and y+1; at (PIXELS_X,PIXELS_Y), wrap to (0,0).
  - Delay line shifts one entry. writeLoc is the read location from PIPE_DEPTH advances earlier.
- Hold (hold_locs=1, Reset=0): every register keeps its value, including the fill count. frame_done is forced 0.
- Fill:
  - Fill counter saturates at PIPE_DEPTH.
  - write_valid=1 once PIPE_DEPTH advances have occurred since reset.
  - Before that, writeLoc reads 0,0 with write_valid=0.
- frame_done=1 for the cycle after an advance in which writeLoc was (PIXELS_X,PIXELS_Y) and write_valid=1.
  - frame_count increments on that same edge and wraps modulo 2^FC_bits.
- Controller interlock:
  - The downstream controller raises hold_locs combinationally from its state, one edge after it sees writeLoc at bottom-right.
  - Therefore the sweeper always performs one more advance and parks with writeLoc=(0,0) and readLoc=(PIPE_DEPTH mod raster position).
  - This is required behaviour: the next frame resumes cleanly from (0,0).
- Bottom-right compare uses equality only. Coordinates never exceed PIXELS_X/PIXELS_Y.
- Widths: counters are exactly X_bits/Y_bits. PIXELS_X < 2^X_bits and PIXELS_Y < 2^Y_bits are required; elaboration check fails otherwise.
- hold_locs is registered by nobody here. It is used directly as the advance enable.
- Reset mid-frame: the next edge returns everything to the reset state regardless of hold_locs. Delay line contents are discarded.

Decomposition:
- Shared params package provides X_bits, Y_bits, PIXELS_X, PIXELS_Y, PIPE_DEPTH, DEBUG_MODE.
- Add a packed typedef loc_t {x, y} to that package, used by the counter, the delay line and the env cache.
- One sub-module: loc_delay_line.
  - Enable-gated shift register of PIPE_DEPTH loc_t entries plus a valid bit per stage.
  - Synchronous active-high reset.

Test Plan (PIXELS_X=3, PIXELS_Y=2, PIPE_DEPTH=2, FC_bits=4):
- Reset held 3 edges, then released with hold=0 → read (0,0),(1,0),(2,0)…; writeLoc (0,0) with write_valid=0 for 2 edges, then write_valid=1 with writeLoc (0,0),(1,0),(2,0),(3,0),(0,1).
- Free-run 12 advances after fill → writeLoc passes (3,2) then (0,0); frame_done pulses exactly once; frame_count=1.
- Emulate controller: raise hold one edge after writeLoc=(3,2) → writeLoc parks at (0,0), readLoc at (2,0); 20 held edges leave outputs unchanged and frame_done=0.
- hold toggled 1/0 every edge mid-row → locations advance only on hold=0 edges; sequence identical to free-run, just stretched.
- Reset asserted with hold=1 while writeLoc=(2,1) → next edge all outputs 0, write_valid=0, frame_count=0.
- 16 full frames → frame_count wraps 15→0 with frame_done still pulsing.
